multicycle_ctrl: RTL and testbench

Multicycle control unit: the issuing end of the instruction-register write interface. It sequences each instruction through fetch, decode, execute, memory and write-back states, pulses `IRWre` during fetch, and consumes the opcode the IR returns. It drives every datapath enable and select for the multicycle CPU.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 62 ++++++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control unit.
//   - opcode constants (instruction[31:26])
//   - FSM state encodings
//   - ALUOp, PCSrc and RegDst codes
//   - op_class_e: coarse instruction class used by the sequencer
package ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    S_IF      = 4'b0000,
    S_ID      = 4'b0001,
    S_EXE_MEM = 4'b0010,
    S_MEM     = 4'b0011,
    S_WB_LD   = 4'b0100,
    S_EXE_BR  = 4'b0101,
    S_EXE_AL  = 4'b0110,
    S_WB_AL   = 4'b0111,
    S_HALT    = 4'b1000
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [2:0] {
    C_AL   = 3'd0,
    C_BR   = 3'd1,
    C_MEM  = 3'd2,
    C_JMP  = 3'd3,
    C_HALT = 3'd4,
    C_ILL  = 3'd5
  } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode decoder.
// Ports:
//   op_i           opcode from the IR
//   cls_o          instruction class for the sequencer
//   alu_src_a_o    1 = shamt on ALU A
//   alu_src_b_o    1 = extended immediate on ALU B
//   ext_sel_o      1 = sign-extend, 0 = zero-extend
//   wr_reg_d_src_o 0 = PC+4 (jal), 1 = DB
//   reg_dst_o      destination register select
//   alu_op_o       ALU operation
//   pc_src_o       op-derived PC select; PC_BRANCH here is only a candidate,
//                  the top qualifies it with state and zero
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output op_class_e  cls_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       ext_sel_o,
  output logic       wr_reg_d_src_o,
  output logic [1:0] reg_dst_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o
);

  always_comb begin
    cls_o          = C_ILL;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 1'b0;
    ext_sel_o      = 1'b1;
    wr_reg_d_src_o = 1'b1;
    reg_dst_o      = RD_RT;
    alu_op_o       = ALU_ADD;
    pc_src_o       = PC_NEXT;
    case (op_i)
      OP_ADD:  begin cls_o = C_AL; reg_dst_o = RD_RD; end
      OP_SUB:  begin cls_o = C_AL; reg_dst_o = RD_RD; alu_op_o = ALU_SUB; end
      OP_OR:   begin cls_o = C_AL; reg_dst_o = RD_RD; alu_op_o = ALU_OR; end
      OP_AND:  begin cls_o = C_AL; reg_dst_o = RD_RD; alu_op_o = ALU_AND; end
      OP_SLT:  begin cls_o = C_AL; reg_dst_o = RD_RD; alu_op_o = ALU_SLT; end
      OP_SLL:  begin
        cls_o = C_AL; reg_dst_o = RD_RD; alu_op_o = ALU_SLL; alu_src_a_o = 1'b1;
      end
      OP_ADDI: begin cls_o = C_AL; alu_src_b_o = 1'b1; end
      OP_ORI:  begin
        cls_o = C_AL; alu_src_b_o = 1'b1; ext_sel_o = 1'b0; alu_op_o = ALU_OR;
      end
      OP_SLTI: begin cls_o = C_AL; alu_src_b_o = 1'b1; alu_op_o = ALU_SLT; end
      OP_SW, OP_LW: begin cls_o = C_MEM; alu_src_b_o = 1'b1; end
      OP_BEQ:  begin cls_o = C_BR; alu_op_o = ALU_SUB; pc_src_o = PC_BRANCH; end
      OP_J:    begin cls_o = C_JMP; pc_src_o = PC_JUMP; end
      OP_JR:   begin cls_o = C_JMP; pc_src_o = PC_RS; end
      OP_JAL:  begin
        cls_o = C_JMP; pc_src_o = PC_JUMP; reg_dst_o = RD_RA; wr_reg_d_src_o = 1'b0;
      end
      OP_HALT: cls_o = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: state sequencer and enable generation for the multicycle CPU.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unlisted opcode halts the core
// and sets the sticky illegal_op flag; otherwise it executes as a 2-cycle NOP).
// Ports:
//   CLK, Reset (sync, active-high), op (IR opcode), zero (ALU flag)
//   IRWre, PCWre, RegWre, mRD, mWR : write/strobe enables
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp : selects
//   halted, illegal_op : status
//
// state     | meaning
// S_IF      | fetch, IR written on this cycle's negedge
// S_ID      | decode; jumps finish here
// S_EXE_AL  | ALU operation for arithmetic/logic
// S_WB_AL   | ALU result written back, PC advances
// S_EXE_BR  | beq compare, PC updates
// S_EXE_MEM | address calculation for lw/sw
// S_MEM     | memory access; sw finishes here
// S_WB_LD   | load data written back
// S_HALT    | stopped until Reset
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       IRWre,
  output logic       PCWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       halted,
  output logic       illegal_op
);

  state_e    state_q, state_d;
  op_class_e cls;
  logic [1:0] dec_pc_src;

  ctrl_decode u_decode (
    .op_i           (op),
    .cls_o          (cls),
    .alu_src_a_o    (ALUSrcA),
    .alu_src_b_o    (ALUSrcB),
    .ext_sel_o      (ExtSel),
    .wr_reg_d_src_o (WrRegDSrc),
    .reg_dst_o      (RegDst),
    .alu_op_o       (ALUOp),
    .pc_src_o       (dec_pc_src)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls)
          C_JMP:   state_d = S_IF;
          C_BR:    state_d = S_EXE_BR;
          C_MEM:   state_d = S_EXE_MEM;
          C_AL:    state_d = S_EXE_AL;
          C_HALT:  state_d = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
          default: state_d = S_HALT;
`else
          default: state_d = S_IF;
`endif
        endcase
      end
      S_EXE_AL:  state_d = S_WB_AL;
      S_WB_AL:   state_d = S_IF;
      S_EXE_BR:  state_d = S_IF;
      S_EXE_MEM: state_d = S_MEM;
      S_MEM:     state_d = (op == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:   state_d = S_IF;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IF;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // set on the same edge that enters S_HALT from an unlisted opcode
      if (state_q == S_ID && cls == C_ILL) illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q & ~Reset;
`else
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign illegal_op = 1'b0;
`endif

  // Enables are forced low during Reset so an aborted instruction never commits.
  always_comb begin
    IRWre  = 1'b0;
    PCWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (cls == C_JMP) begin
            PCWre  = 1'b1;
            RegWre = (op == OP_JAL);
          end
`ifndef ILLEGAL_OP_TRAP_EN
          else if (cls == C_ILL) PCWre = 1'b1;
`endif
        end
        S_EXE_BR: PCWre = 1'b1;
        S_MEM: begin
          if (op == OP_LW) mRD = 1'b1;
          else if (op == OP_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_AL, S_WB_LD: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // beq only redirects the PC in its execute cycle with a taken compare.
  always_comb begin
    PCSrc = dec_pc_src;
    if (dec_pc_src == PC_BRANCH)
      PCSrc = (state_q == S_EXE_BR && zero) ? PC_BRANCH : PC_NEXT;
  end

  assign DBDataSrc = (state_q == S_WB_LD);
  assign halted    = (state_q == S_HALT) & ~Reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       CLK, Reset, zero;
  logic [5:0] op;
  logic       IRWre, PCWre, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic       halted, illegal_op;
  logic [4:0] en;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
    .IRWre(IRWre), .PCWre(PCWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted), .illegal_op(illegal_op)
  );

  // {IRWre, PCWre, RegWre, mRD, mWR}
  assign en = {IRWre, PCWre, RegWre, mRD, mWR};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // check the enable vector for the current cycle, then advance one cycle
  task automatic ec(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, en}, {27'd0, exp});
    step();
  endtask

  initial begin
    Reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;

    // reset held for two cycles
    step();
    chk("rst_en1", {27'd0, en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    step();
    chk("rst_en2", {27'd0, en}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rst_if_irwre", {31'd0, IRWre}, 32'd1);

    // addi: 4 cycles
    op = 6'b000010;
    #1;
    chk("addi_srcb", {31'd0, ALUSrcB}, 32'd1);
    chk("addi_ext", {31'd0, ExtSel}, 32'd1);
    chk("addi_aluop", {29'd0, ALUOp}, 32'd0);
    ec("addi_c1", 5'b10000);
    ec("addi_c2", 5'b00000);
    ec("addi_c3", 5'b00000);
    chk("addi_regdst", {30'd0, RegDst}, 32'd1);
    ec("addi_c4", 5'b01100);

    // beq taken: 3 cycles; zero high outside execute must not redirect
    op = 6'b110100;
    #1;
    chk("beq_aluop", {29'd0, ALUOp}, 32'd1);
    ec("beqt_c1", 5'b10000);
    zero = 1'b1;
    #1;
    chk("beqt_pcsrc_id", {30'd0, PCSrc}, 32'd0);
    ec("beqt_c2", 5'b00000);
    chk("beqt_pcsrc", {30'd0, PCSrc}, 32'd1);
    ec("beqt_c3", 5'b01000);

    // beq not taken
    zero = 1'b0;
    ec("beqn_c1", 5'b10000);
    ec("beqn_c2", 5'b00000);
    chk("beqn_pcsrc", {30'd0, PCSrc}, 32'd0);
    ec("beqn_c3", 5'b01000);

    // lw: 5 cycles
    op = 6'b110001;
    ec("lw_c1", 5'b10000);
    ec("lw_c2", 5'b00000);
    ec("lw_c3", 5'b00000);
    chk("lw_dbsrc_c4", {31'd0, DBDataSrc}, 32'd0);
    ec("lw_c4", 5'b00010);
    chk("lw_dbsrc_c5", {31'd0, DBDataSrc}, 32'd1);
    chk("lw_regdst", {30'd0, RegDst}, 32'd1);
    ec("lw_c5", 5'b01100);

    // sw: 4 cycles
    op = 6'b110000;
    ec("sw_c1", 5'b10000);
    ec("sw_c2", 5'b00000);
    ec("sw_c3", 5'b00000);
    ec("sw_c4", 5'b01001);

    // jal: 2 cycles
    op = 6'b111010;
    ec("jal_c1", 5'b10000);
    chk("jal_regdst", {30'd0, RegDst}, 32'd0);
    chk("jal_wrsrc", {31'd0, WrRegDSrc}, 32'd0);
    chk("jal_pcsrc", {30'd0, PCSrc}, 32'd3);
    ec("jal_c2", 5'b01100);

    // j and jr
    op = 6'b111000;
    ec("j_c1", 5'b10000);
    chk("j_pcsrc", {30'd0, PCSrc}, 32'd3);
    ec("j_c2", 5'b01000);
    op = 6'b111001;
    ec("jr_c1", 5'b10000);
    chk("jr_pcsrc", {30'd0, PCSrc}, 32'd2);
    ec("jr_c2", 5'b01000);

    // sll and ori selects
    op = 6'b011000;
    #1;
    chk("sll_srca", {31'd0, ALUSrcA}, 32'd1);
    chk("sll_aluop", {29'd0, ALUOp}, 32'd2);
    chk("sll_regdst", {30'd0, RegDst}, 32'd2);
    ec("sll_c1", 5'b10000);
    ec("sll_c2", 5'b00000);
    ec("sll_c3", 5'b00000);
    ec("sll_c4", 5'b01100);
    op = 6'b010010;
    #1;
    chk("ori_ext", {31'd0, ExtSel}, 32'd0);
    chk("ori_aluop", {29'd0, ALUOp}, 32'd3);
    chk("ori_srcb", {31'd0, ALUSrcB}, 32'd1);
    op = 6'b100111;
    #1;
    chk("slti_aluop", {29'd0, ALUOp}, 32'd5);

    // reset aborts lw in its memory cycle
    op = 6'b110001;
    ec("abort_c1", 5'b10000);
    ec("abort_c2", 5'b00000);
    ec("abort_c3", 5'b00000);
    Reset = 1'b1;
    #1;
    chk("abort_en", {27'd0, en}, 32'd0);
    step();
    Reset = 1'b0;
    #1;
    chk("abort_restart", {31'd0, IRWre}, 32'd1);

    // halt: absorbing for 10 cycles, then Reset restarts
    op = 6'b111111;
    ec("halt_c1", 5'b10000);
    chk("halt_id_halted", {31'd0, halted}, 32'd0);
    ec("halt_c2", 5'b00000);
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_illegal", {31'd0, illegal_op}, 32'd0);
      ec("halt_en", 5'b00000);
    end
    Reset = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_en", {27'd0, en}, 32'd0);
    step();
    Reset = 1'b0;
    #1;
    chk("halt_restart", {31'd0, IRWre}, 32'd1);

    // unlisted opcode
    op = 6'b101010;
    ec("ill_c1", 5'b10000);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_flag_id", {31'd0, illegal_op}, 32'd0);
    ec("ill_c2", 5'b00000);
    chk("ill_flag", {31'd0, illegal_op}, 32'd1);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    ec("ill_c3", 5'b00000);
    chk("ill_flag_sticky", {31'd0, illegal_op}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("ill_flag_rst", {31'd0, illegal_op}, 32'd0);
    step();
    Reset = 1'b0;
`else
    chk("ill_pcsrc", {30'd0, PCSrc}, 32'd0);
    ec("ill_c2", 5'b01000);
    chk("ill_next_if", {31'd0, IRWre}, 32'd1);
    chk("ill_flag", {31'd0, illegal_op}, 32'd0);
    chk("ill_halted", {31'd0, halted}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
